// File: rtl/pin_check_pkg.sv
// Shared types and helpers for the pin check monitor.
package pin_check_pkg;

   // Number of pad nets watched (PIN1..PIN4)
   localparam int NUM_PINS = 4;

   // Monitor states: waiting for enable, letting pads settle, actively comparing
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2
   } state_t;

   // Increment that holds at maxVal instead of wrapping
   function automatic logic [31:0] satInc(input logic [31:0] value,
                                          input logic [31:0] maxVal);
      if (value >= maxVal) begin
         return maxVal;
      end
      return value + 32'd1;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for bringing asynchronous levels into the clock domain.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // First flop may go metastable; second flop gives it a full cycle to resolve
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pin_check_monitor.sv
// Observes the four pad nets while checking is enabled and records mismatches
// against an expected value under a mask. Never drives the pins.
module pin_check_monitor
   import pin_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = 8,
   parameter int DEGLITCH      = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_check_en,
   input  logic [NUM_PINS-1:0] i_pin_in,
   input  logic [NUM_PINS-1:0] i_exp_val,
   input  logic [NUM_PINS-1:0] i_exp_mask,
   output logic                o_checking,
   output logic                o_err,
   output logic [CNT_W-1:0]    o_err_cnt,
   output logic [NUM_PINS-1:0] o_first_err_pins,
   output logic [NUM_PINS-1:0] o_err_pin_mask
);

   localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [2:0]       DG_LAST     = 3'(DEGLITCH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   logic                w_enSync;
   logic [NUM_PINS-1:0] w_pinSync;
   logic                w_enRise;
   logic [NUM_PINS-1:0] w_mm;
   logic                w_mismatch;

   logic                r_enPrev;
   state_t              r_state;
   state_t              w_stateNext;
   logic [7:0]          r_settleCnt;
   logic [7:0]          w_settleNext;
   logic [2:0]          r_dgCnt;
   logic [2:0]          w_dgNext;
   logic                r_err;
   logic                w_errNext;
   logic [CNT_W-1:0]    r_errCnt;
   logic [CNT_W-1:0]    w_errCntNext;
   logic [NUM_PINS-1:0] r_firstPins;
   logic [NUM_PINS-1:0] w_firstPinsNext;
   logic [NUM_PINS-1:0] r_errMask;
   logic [NUM_PINS-1:0] w_errMaskNext;

   sync2 #(.WIDTH(1)) uSyncEn (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_check_en),
      .o_q     (w_enSync)
   );

   sync2 #(.WIDTH(NUM_PINS)) uSyncPins (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_pin_in),
      .o_q     (w_pinSync)
   );

   assign w_enRise = w_enSync & ~r_enPrev;
   assign w_mm     = (w_pinSync ^ i_exp_val) & i_exp_mask;

   // Match only on a clean zero so an unknown masked-in pin falls to mismatch
   always_comb begin
      w_mismatch = 1'b1;
      if (w_mm == '0) begin
         w_mismatch = 1'b0;
      end
   end

   // Remember last enable level so a fresh arm is seen exactly once
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_enPrev <= 1'b0;
      end else begin
         r_enPrev <= w_enSync;
      end
   end

   // Next-state and result update: arm/clear, settle countdown, deglitched compare
   always_comb begin
      w_stateNext     = r_state;
      w_settleNext    = r_settleCnt;
      w_dgNext        = r_dgCnt;
      w_errNext       = r_err;
      w_errCntNext    = r_errCnt;
      w_firstPinsNext = r_firstPins;
      w_errMaskNext   = r_errMask;
      case (r_state)
         IDLE: begin
            if (w_enRise) begin
               w_stateNext     = SETTLE;
               w_settleNext    = SETTLE_LOAD;
               w_dgNext        = '0;
               w_errNext       = 1'b0;
               w_errCntNext    = '0;
               w_firstPinsNext = '0;
               w_errMaskNext   = '0;
            end
         end
         SETTLE: begin
            if (!w_enSync) begin
               w_stateNext = IDLE;
            end else if (r_settleCnt == 8'd0) begin
               w_stateNext = CHECK;
            end else begin
               w_settleNext = r_settleCnt - 8'd1;
            end
         end
         CHECK: begin
            if (w_mismatch) begin
               if (r_dgCnt == DG_LAST) begin
                  w_dgNext      = '0;
                  w_errCntNext  = CNT_W'(satInc(32'(r_errCnt), 32'(CNT_MAX)));
                  w_errMaskNext = r_errMask | w_mm;
                  if (!r_err) begin
                     w_errNext       = 1'b1;
                     w_firstPinsNext = w_pinSync;
                  end
               end else begin
                  w_dgNext = r_dgCnt + 3'd1;
               end
            end else begin
               w_dgNext = '0;
            end
            if (!w_enSync) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State, counters and sticky results; everything clears on reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_settleCnt <= '0;
         r_dgCnt     <= '0;
         r_err       <= 1'b0;
         r_errCnt    <= '0;
         r_firstPins <= '0;
         r_errMask   <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_settleCnt <= w_settleNext;
         r_dgCnt     <= w_dgNext;
         r_err       <= w_errNext;
         r_errCnt    <= w_errCntNext;
         r_firstPins <= w_firstPinsNext;
         r_errMask   <= w_errMaskNext;
      end
   end

   assign o_checking       = (r_state == CHECK);
   assign o_err            = r_err;
   assign o_err_cnt        = r_errCnt;
   assign o_first_err_pins = r_firstPins;
   assign o_err_pin_mask   = r_errMask;

endmodule

// File: tb/tb_pin_check_monitor.sv
// Directed bench for pin_check_monitor with a cycle-level reference model.
module tb_pin_check_monitor;

   localparam int SETTLE = 8;
   localparam int CW     = 4;
   localparam int DG     = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          check_en = 1'b0;
   logic [3:0]    pin_in = 4'h0;
   logic [3:0]    exp_val = 4'h0;
   logic [3:0]    exp_mask = 4'hF;
   logic          o_checking;
   logic          o_err;
   logic [CW-1:0] o_err_cnt;
   logic [3:0]    o_first_err_pins;
   logic [3:0]    o_err_pin_mask;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic       mEn1 = 1'b0;
   logic       mEnS = 1'b0;
   logic [3:0] mPin1 = 4'h0;
   logic [3:0] mPinS = 4'h0;
   int         mRun = 0;
   int         mStreak = 0;
   logic       mChk = 1'b0;
   logic       mErr = 1'b0;
   int         mCnt = 0;
   logic [3:0] mFirst = 4'h0;
   logic [3:0] mMask = 4'h0;
   logic [3:0] mmModel;
   int         runNow;
   logic       chkNow;
   int         lat;

   pin_check_monitor #(
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (CW),
      .DEGLITCH      (DG)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_check_en       (check_en),
      .i_pin_in         (pin_in),
      .i_exp_val        (exp_val),
      .i_exp_mask       (exp_mask),
      .o_checking       (o_checking),
      .o_err            (o_err),
      .o_err_cnt        (o_err_cnt),
      .o_first_err_pins (o_first_err_pins),
      .o_err_pin_mask   (o_err_pin_mask)
   );

   always #5 clk = ~clk;

   // Model: checking holds once the synchronized enable has been high for
   // SETTLE+1 consecutive cycles; every DG-th consecutive mismatching checked
   // sample is one counted error; a new run of enable clears all results.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mEn1 = 1'b0; mEnS = 1'b0; mPin1 = 4'h0; mPinS = 4'h0;
            mRun = 0; mStreak = 0; mChk = 1'b0;
            mErr = 1'b0; mCnt = 0; mFirst = 4'h0; mMask = 4'h0;
         end else begin
            chkNow = (mRun >= SETTLE + 1);
            if (chkNow) begin
               mmModel = (mPinS ^ exp_val) & exp_mask;
               if (mmModel != 4'h0) begin
                  mStreak = mStreak + 1;
                  if (mStreak % DG == 0) begin
                     if (mCnt < (1 << CW) - 1) mCnt = mCnt + 1;
                     mMask = mMask | mmModel;
                     if (!mErr) begin
                        mErr = 1'b1;
                        mFirst = mPinS;
                     end
                  end
               end else begin
                  mStreak = 0;
               end
            end else begin
               mStreak = 0;
            end
            runNow = mEnS ? ((mRun < 1000) ? mRun + 1 : mRun) : 0;
            if (runNow == 1) begin
               mErr = 1'b0; mCnt = 0; mFirst = 4'h0; mMask = 4'h0; mStreak = 0;
            end
            mRun = runNow;
            mChk = (mRun >= SETTLE + 1);
            mEnS = mEn1;
            mEn1 = check_en;
            mPinS = mPin1;
            mPin1 = pin_in;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(negedge clk);
         total++;
         if (o_checking !== mChk || o_err !== mErr || o_err_cnt !== CW'(mCnt) ||
             o_first_err_pins !== mFirst || o_err_pin_mask !== mMask) begin
            bad++;
            $display("[TB] FAIL cycleCompare t=%0t dut/model: checking=%0b/%0b err=%0b/%0b cnt=%0d/%0d first=%b/%b mask=%b/%b",
                     $time, o_checking, mChk, o_err, mErr, o_err_cnt, mCnt,
                     o_first_err_pins, mFirst, o_err_pin_mask, mMask);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] pins,
                                input logic [3:0] ev, input logic [3:0] mask);
      check_en = en;
      pin_in   = pins;
      exp_val  = ev;
      exp_mask = mask;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      $display("[TB] start");
      // Reset and idle behaviour
      waitCycles(3);
      #1;
      checkOutput("resetChecking", int'(o_checking), 0);
      checkOutput("resetErr", int'(o_err), 0);
      checkOutput("resetCnt", int'(o_err_cnt), 0);
      checkOutput("resetFirst", int'(o_first_err_pins), 0);
      checkOutput("resetMask", int'(o_err_pin_mask), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         pin_in = 4'($urandom_range(0, 15));
      end
      waitCycles(1);
      checkOutput("idleErr", int'(o_err), 0);
      checkOutput("idleCnt", int'(o_err_cnt), 0);
      checkOutput("idleChecking", int'(o_checking), 0);

      // Settle timing, with wrong pins while settling
      @(negedge clk);
      applyStimulus(1'b1, 4'b0000, 4'b1010, 4'hF);
      lat = 0;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (o_checking) lat = i;
         if (i == 6) pin_in = 4'b1010;
      end
      @(negedge clk);
      checkOutput("settleLatency", lat, SETTLE + 3);
      checkOutput("settleErr", int'(o_err), 0);

      // Deglitch: single-cycle glitch ignored, two-cycle mismatch counted
      pin_in = 4'b1011;
      waitCycles(1);
      pin_in = 4'b1010;
      waitCycles(5);
      checkOutput("glitchCnt", int'(o_err_cnt), 0);
      pin_in = 4'b1110;
      waitCycles(2);
      pin_in = 4'b1010;
      waitCycles(5);
      checkOutput("dgErr", int'(o_err), 1);
      checkOutput("dgCnt", int'(o_err_cnt), 1);
      checkOutput("dgMask", int'(o_err_pin_mask), 4);
      checkOutput("dgFirst", int'(o_first_err_pins), 14);

      // Disable: checking drops within 3 cycles, results retained
      check_en = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (!o_checking) lat = i;
      end
      @(negedge clk);
      checkOutput("disableLatency", lat, 3);
      checkOutput("heldCnt", int'(o_err_cnt), 1);
      checkOutput("heldMask", int'(o_err_pin_mask), 4);

      // Re-enable clears results at re-arm
      check_en = 1'b1;
      waitCycles(3);
      checkOutput("rearmCnt", int'(o_err_cnt), 0);
      checkOutput("rearmErr", int'(o_err), 0);
      checkOutput("rearmMask", int'(o_err_pin_mask), 0);
      lat = 0;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (o_checking) lat = i;
      end
      @(negedge clk);
      checkOutput("rearmChecking", int'(o_checking), 1);

      // Mask: PIN4 ignored, then PIN2 wrong for 10 cycles
      exp_mask = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         pin_in = (i % 2 == 0) ? 4'b0010 : 4'b1010;
         waitCycles(1);
      end
      pin_in = 4'b1010;
      waitCycles(3);
      checkOutput("maskedCnt", int'(o_err_cnt), 0);
      pin_in = 4'b1000;
      waitCycles(10);
      pin_in = 4'b1010;
      waitCycles(4);
      checkOutput("accumCnt", int'(o_err_cnt), 5);
      checkOutput("accumMask", int'(o_err_pin_mask), 2);
      checkOutput("accumFirst", int'(o_first_err_pins), 8);

      // Saturation under persistent mismatch
      exp_mask = 4'hF;
      pin_in = 4'b0101;
      waitCycles(40);
      pin_in = 4'b1010;
      waitCycles(4);
      checkOutput("satCnt", int'(o_err_cnt), 15);
      checkOutput("satErr", int'(o_err), 1);
      checkOutput("satMask", int'(o_err_pin_mask), 15);
      checkOutput("satFirst", int'(o_first_err_pins), 8);

      // Asynchronous reset in the middle of CHECK
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRstChecking", int'(o_checking), 0);
      checkOutput("asyncRstErr", int'(o_err), 0);
      checkOutput("asyncRstCnt", int'(o_err_cnt), 0);
      checkOutput("asyncRstMask", int'(o_err_pin_mask), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Enable already high out of reset still arms
      lat = 0;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (o_checking) lat = i;
      end
      @(negedge clk);
      checkOutput("armAfterReset", int'(lat != 0), 1);
      waitCycles(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
